// File: rtl/multicore_pkg.sv
// Shared types for the multicore execute stage: system-op encoding, trap causes,
// system-unit FSM states and the architectural counter width.
package multicore_pkg;

  typedef enum logic [3:0] {
    SYSOP_RDCYCLE    = 4'd0,
    SYSOP_RDCYCLEH   = 4'd1,
    SYSOP_RDTIME     = 4'd2,
    SYSOP_RDTIMEH    = 4'd3,
    SYSOP_RDINSTRET  = 4'd4,
    SYSOP_RDINSTRETH = 4'd5,
    SYSOP_SCALL      = 4'd6,
    SYSOP_SBREAK     = 4'd7
  } t_sysop;

  typedef enum logic {
    CAUSE_ECALL = 1'b0,
    CAUSE_BREAK = 1'b1
  } t_trap_cause;

  typedef enum logic {
    SYS_IDLE = 1'b0,
    SYS_TRAP = 1'b1
  } t_sys_state;

  localparam int CNT_W = 64;

  // Select the upper or lower 32-bit half of a counter.
  function automatic logic [31:0] cnt_half(input logic [CNT_W-1:0] v, input logic hi);
    return hi ? v[CNT_W-1:CNT_W/2] : v[CNT_W/2-1:0];
  endfunction

endpackage

// File: rtl/sys_counter.sv
// Free-running wrap-around counter with synchronous reset, load and count enable.
module sys_counter
  import multicore_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/system_unit.sv
// Execute-stage system unit: cycle/time/instret counters, RD* reads and an
// SCALL/SBREAK trap request with request/acknowledge handshake.
module system_unit
  import multicore_pkg::*;
#(
  parameter int TIME_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  t_sysop      i_sysop,
  input  logic        i_stall,
  input  logic        i_retire,
  input  logic        i_trap_ack,
  output logic [31:0] o_result,
  output logic        o_result_valid,
  output logic        o_trap_req,
  output t_trap_cause o_trap_cause,
  output logic        o_busy
);

  localparam int PW = $clog2(TIME_DIV + 1);

  logic [PW-1:0]    r_presc;
  t_sys_state       r_state;
  t_trap_cause      r_cause;
  logic [31:0]      r_result;
  logic             r_result_valid;

  logic             w_time_tick;
  logic             w_accept;
  logic             w_is_trap_op;
  logic [31:0]      w_rd_val;
  logic             w_cyc_load;
  logic [CNT_W-1:0] w_cyc_load_val;
  logic [CNT_W-1:0] w_cycle;
  logic [CNT_W-1:0] w_time;
  logic [CNT_W-1:0] w_instret;

  // Cycle-counter preload is tied off in normal operation.
  assign w_cyc_load     = 1'b0;
  assign w_cyc_load_val = '0;

  assign w_time_tick  = (r_presc == PW'(TIME_DIV - 1));
  assign o_busy       = (r_state == SYS_TRAP);
  assign w_accept     = i_valid & ~i_stall & ~o_busy;
  assign w_is_trap_op = (i_sysop == SYSOP_SCALL) || (i_sysop == SYSOP_SBREAK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (w_time_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  sys_counter #(.W(CNT_W)) u_cycle (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (1'b1),
    .i_load     (w_cyc_load),
    .i_load_val (w_cyc_load_val),
    .o_cnt      (w_cycle)
  );

  sys_counter #(.W(CNT_W)) u_time (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (w_time_tick),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (w_time)
  );

  sys_counter #(.W(CNT_W)) u_instret (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_retire),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_cnt      (w_instret)
  );

  // Unknown encodings read the low cycle half, like the decoder default.
  always_comb begin
    w_rd_val = cnt_half(w_cycle, 1'b0);
    case (i_sysop)
      SYSOP_RDCYCLEH:   w_rd_val = cnt_half(w_cycle, 1'b1);
      SYSOP_RDTIME:     w_rd_val = cnt_half(w_time, 1'b0);
      SYSOP_RDTIMEH:    w_rd_val = cnt_half(w_time, 1'b1);
      SYSOP_RDINSTRET:  w_rd_val = cnt_half(w_instret, 1'b0);
      SYSOP_RDINSTRETH: w_rd_val = cnt_half(w_instret, 1'b1);
      default:          w_rd_val = cnt_half(w_cycle, 1'b0);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_accept & ~w_is_trap_op;
      if (w_accept && !w_is_trap_op) begin
        r_result <= w_rd_val;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SYS_IDLE;
      r_cause <= CAUSE_ECALL;
    end else begin
      case (r_state)
        SYS_IDLE: begin
          if (w_accept && w_is_trap_op) begin
            r_state <= SYS_TRAP;
            r_cause <= (i_sysop == SYSOP_SBREAK) ? CAUSE_BREAK : CAUSE_ECALL;
          end
        end
        SYS_TRAP: begin
          if (i_trap_ack) begin
            r_state <= SYS_IDLE;
          end
        end
        default: r_state <= SYS_IDLE;
      endcase
    end
  end

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_trap_req     = (r_state == SYS_TRAP);
  assign o_trap_cause   = r_cause;

endmodule

// File: tb/tb_system_unit.sv
// Scoreboard bench for system_unit: reads push expected results into a queue,
// a monitor pops and compares on every o_result_valid pulse.
module tb_system_unit;
  import multicore_pkg::*;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  t_sysop      i_sysop;
  logic        i_stall;
  logic        i_retire;
  logic        i_trap_ack;
  logic [31:0] o_result;
  logic        o_result_valid;
  logic        o_trap_req;
  t_trap_cause o_trap_cause;
  logic        o_busy;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } t_exp;

  t_exp        q[$];
  int          n_vec;
  int          n_err;
  logic [63:0] edge_cnt;

  system_unit #(.TIME_DIV(4)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .i_sysop        (i_sysop),
    .i_stall        (i_stall),
    .i_retire       (i_retire),
    .i_trap_ack     (i_trap_ack),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_trap_req     (o_trap_req),
    .o_trap_cause   (o_trap_cause),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: non-reset edges since the last reset edge.
  always @(posedge clk) begin
    if (i_reset) edge_cnt <= '0;
    else         edge_cnt <= edge_cnt + 64'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input logic [31:0] v);
    t_exp e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic issue(input t_sysop op);
    i_valid = 1'b1;
    i_sysop = op;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_valid    = 1'b0;
    i_stall    = 1'b0;
    i_retire   = 1'b0;
    i_trap_ack = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic monitor();
    t_exp e;
    forever begin
      @(negedge clk);
      if (o_result_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: got o_result %h with no read outstanding", o_result);
        end else begin
          e = q.pop_front();
          check(e.nm, o_result, e.v);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ev;
    t_sysop      bad_op;
    n_vec      = 0;
    n_err      = 0;
    i_reset    = 1'b1;
    i_valid    = 1'b0;
    i_sysop    = SYSOP_RDCYCLE;
    i_stall    = 1'b0;
    i_retire   = 1'b0;
    i_trap_ack = 1'b0;
    fork
      monitor();
    join_none

    // Reset state and first read at cycle 10
    do_reset();
    check("rst_result", o_result, 32'h0);
    check("rst_valid", {31'b0, o_result_valid}, 32'h0);
    check("rst_trap_req", {31'b0, o_trap_req}, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    check("rst_cause", {31'b0, o_trap_cause}, {31'b0, CAUSE_ECALL});
    repeat (10) tick();
    expect_res("rdcycle_10", 32'd10);
    issue(SYSOP_RDCYCLE);
    tick();
    check("pulse_drop", {31'b0, o_result_valid}, 32'h0);
    check("result_hold", o_result, 32'd10);

    // Carry into the high half
    force dut.w_cyc_load     = 1'b1;
    force dut.w_cyc_load_val = 64'h0000_0000_FFFF_FFFF;
    tick();
    release dut.w_cyc_load;
    release dut.w_cyc_load_val;
    tick();
    expect_res("rdcycleh_carry", 32'd1);
    issue(SYSOP_RDCYCLEH);
    expect_res("rdcycle_carry", 32'd1);
    issue(SYSOP_RDCYCLE);

    // 64-bit wrap
    force dut.w_cyc_load     = 1'b1;
    force dut.w_cyc_load_val = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.w_cyc_load;
    release dut.w_cyc_load_val;
    tick();
    expect_res("rdcycle_wrap", 32'd0);
    issue(SYSOP_RDCYCLE);
    expect_res("rdcycleh_wrap", 32'd0);
    issue(SYSOP_RDCYCLEH);

    // Time counter with TIME_DIV=4
    do_reset();
    repeat (20) tick();
    expect_res("rdtime_20", 32'd5);
    issue(SYSOP_RDTIME);
    expect_res("rdtimeh", 32'd0);
    issue(SYSOP_RDTIMEH);

    // SBREAK trap, held read, retires across the trap
    do_reset();
    i_retire = 1'b1; tick();
    i_retire = 1'b0; tick();
    i_retire = 1'b1; tick();
    i_retire = 1'b0;
    i_valid  = 1'b1;
    i_sysop  = SYSOP_SBREAK;
    tick();
    check("sbreak_req", {31'b0, o_trap_req}, 32'h1);
    check("sbreak_busy", {31'b0, o_busy}, 32'h1);
    check("sbreak_cause", {31'b0, o_trap_cause}, {31'b0, CAUSE_BREAK});
    i_sysop  = SYSOP_RDCYCLE;
    i_retire = 1'b1;
    tick();
    check("trap_hold_req", {31'b0, o_trap_req}, 32'h1);
    i_retire = 1'b0; tick();
    i_retire = 1'b1; tick();
    i_retire   = 1'b0;
    i_trap_ack = 1'b1;
    tick();
    i_trap_ack = 1'b0;
    check("ack_req_drop", {31'b0, o_trap_req}, 32'h0);
    check("ack_busy_drop", {31'b0, o_busy}, 32'h0);
    expect_res("held_rdcycle", 32'd8);
    tick();
    i_valid = 1'b0;
    i_retire = 1'b1; tick();
    i_retire = 1'b0; tick();
    i_retire = 1'b1; tick();
    i_retire   = 1'b0;
    i_trap_ack = 1'b1;
    tick();
    i_trap_ack = 1'b0;
    check("ack_in_idle", {31'b0, o_trap_req}, 32'h0);
    i_retire = 1'b1; tick();
    i_retire = 1'b0;
    expect_res("rdinstret_7", 32'd7);
    issue(SYSOP_RDINSTRET);

    // Reset during a pending SCALL trap
    issue(SYSOP_SCALL);
    check("scall_req", {31'b0, o_trap_req}, 32'h1);
    check("scall_cause", {31'b0, o_trap_cause}, {31'b0, CAUSE_ECALL});
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rst_trap_req_drop", {31'b0, o_trap_req}, 32'h0);
    check("rst_trap_busy_drop", {31'b0, o_busy}, 32'h0);
    check("rst_trap_result", o_result, 32'h0);
    expect_res("rst_cycle", 32'd0);
    issue(SYSOP_RDCYCLE);
    expect_res("rst_time", 32'd0);
    issue(SYSOP_RDTIME);
    expect_res("rst_instret", 32'd0);
    issue(SYSOP_RDINSTRET);

    // Stalled read
    i_retire = 1'b1; tick();
    i_retire = 1'b0; tick();
    i_retire = 1'b1; tick();
    i_retire = 1'b0;
    i_valid  = 1'b1;
    i_sysop  = SYSOP_RDINSTRET;
    i_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_no_pulse", {31'b0, o_result_valid}, 32'h0);
    end
    i_stall = 1'b0;
    expect_res("stall_rdinstret", 32'd2);
    tick();
    i_valid = 1'b0;
    check("stall_pulse", {31'b0, o_result_valid}, 32'h1);

    // Unknown encoding reads the low cycle half
    tick();
    ev     = edge_cnt[31:0];
    bad_op = t_sysop'(4'hF);
    expect_res("unknown_op", ev);
    issue(bad_op);

    repeat (3) tick();
    while (q.size() > 0) begin
      t_exp e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: got no response expected %h", e.nm, e.v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
